// File: rtl/bubble_sort_engine.sv
`default_nettype none
// ============================================================================
// Module      : bubble_sort_engine
// Description : In-place bubble sort of an external word-addressed memory
//               through a single read/write request port with a
//               mem_ready handshake. Exits early on a pass with no swaps.
// Revision    : 1.0 - initial release
// ============================================================================
module bubble_sort_engine #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              desc_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_rd_o,
    output logic              mem_wr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [15:0]       swap_count_o
);

    localparam logic [ADDR_W-1:0] C_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] C_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_CMP  = 3'd3,
        S_WR_A = 3'd4,
        S_WR_B = 3'd5,
        S_NEXT = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   idx_q;          // left element of the current pair
    logic [ADDR_W-1:0]   lim_q;          // pairs with idx+1 < lim remain in this pass
    logic                swapped_q;      // any swap seen in the current pass
    logic                desc_q;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_rd_q;
    logic                mem_wr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                busy_q;
    logic                done_q;
    logic [15:0]         swap_count_q;

    logic [ADDR_W-1:0]   idx_inc_d;
    logic                swap_needed_d;
    logic [15:0]         swap_count_d;

    // idx never exceeds DEPTH-2, so idx+1 always fits in ADDR_W bits
    assign idx_inc_d     = idx_q + C_ONE;
    // Equal elements never swap, which keeps the sort stable
    assign swap_needed_d = desc_q ? (a_q < b_q) : (a_q > b_q);
    assign swap_count_d  = (swap_count_q == 16'hFFFF) ? swap_count_q
                                                      : swap_count_q + 16'd1;

    // Sort sequencer with registered memory-request and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            lim_q        <= C_LAST;
            swapped_q    <= 1'b0;
            desc_q       <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            swap_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q      <= S_RD_A;
                        idx_q        <= '0;
                        lim_q        <= C_LAST;
                        swapped_q    <= 1'b0;
                        swap_count_q <= '0;
                        desc_q       <= desc_i;
                        busy_q       <= 1'b1;
                        mem_rd_q     <= 1'b1;
                        mem_addr_q   <= '0;
                    end
                end
                S_RD_A: begin
                    if (mem_ready_i) begin
                        a_q        <= mem_rdata_i;
                        mem_addr_q <= idx_inc_d;
                        state_q    <= S_RD_B;
                    end
                end
                S_RD_B: begin
                    if (mem_ready_i) begin
                        b_q      <= mem_rdata_i;
                        mem_rd_q <= 1'b0;
                        state_q  <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (swap_needed_d) begin
                        mem_wr_q    <= 1'b1;
                        mem_addr_q  <= idx_q;
                        mem_wdata_q <= b_q;
                        state_q     <= S_WR_A;
                    end else begin
                        state_q <= S_NEXT;
                    end
                end
                S_WR_A: begin
                    if (mem_ready_i) begin
                        mem_addr_q  <= idx_inc_d;
                        mem_wdata_q <= a_q;
                        state_q     <= S_WR_B;
                    end
                end
                S_WR_B: begin
                    if (mem_ready_i) begin
                        mem_wr_q     <= 1'b0;
                        swapped_q    <= 1'b1;
                        swap_count_q <= swap_count_d;
                        state_q      <= S_NEXT;
                    end
                end
                S_NEXT: begin
                    if (idx_inc_d < lim_q) begin
                        idx_q      <= idx_inc_d;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= idx_inc_d;
                        state_q    <= S_RD_A;
                    end else if (!swapped_q || (lim_q == C_ONE)) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        lim_q      <= lim_q - C_ONE;
                        idx_q      <= '0;
                        swapped_q  <= 1'b0;
                        mem_rd_q   <= 1'b1;
                        mem_addr_q <= '0;
                        state_q    <= S_RD_A;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign mem_rd_o     = mem_rd_q;
    assign mem_wr_o     = mem_wr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign swap_count_o = swap_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bubble_sort_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_bubble_sort_engine
// Description : Directed self-checking bench for bubble_sort_engine with a
//               4-word memory model and optional random mem_ready delay.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bubble_sort_engine;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start_i = 1'b0;
    logic              desc_i = 1'b0;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_rd_o;
    logic              mem_wr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_ready_i;
    logic              busy_o;
    logic              done_o;
    logic [15:0]       swap_count_o;

    int vectors = 0;
    int miscompares = 0;

    // memory model state
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] load_vals [DEPTH];
    logic              load_en = 1'b0;
    int                max_delay = 0;
    logic              force_ready = 1'b0;
    logic              ready_q = 1'b0;
    int                wait_cnt = 0;

    // monitor state
    int                mon_err = 0;
    int                rd_cnt = 0;
    int                wr_cnt = 0;
    int                done_cycles = 0;
    logic              pend = 1'b0;
    logic              pend_rd, pend_wr;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_wdata;

    bubble_sort_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .desc_i       (desc_i),
        .mem_addr_o   (mem_addr_o),
        .mem_rd_o     (mem_rd_o),
        .mem_wr_o     (mem_wr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_rdata_i  (mem_rdata_i),
        .mem_ready_i  (mem_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .swap_count_o (swap_count_o)
    );

    always #5 clk = ~clk;

    assign mem_rdata_i = mem[mem_addr_o];
    assign mem_ready_i = ready_q | force_ready;

    // Decide on each falling edge whether the pending request completes next
    always @(negedge clk) begin
        if (rst) begin
            ready_q  <= 1'b0;
            wait_cnt <= 0;
        end else if (mem_rd_o || mem_wr_o) begin
            if (wait_cnt == 0) begin
                ready_q  <= 1'b1;
                wait_cnt <= (max_delay > 0) ? int'($urandom_range(max_delay, 0)) : 0;
            end else begin
                ready_q  <= 1'b0;
                wait_cnt <= wait_cnt - 1;
            end
        end else begin
            ready_q <= 1'b0;
        end
    end

    // Memory array: bulk load from the bench or single-word writes from the DUT
    always @(posedge clk) begin
        if (load_en) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= load_vals[k];
        end else if (mem_wr_o && mem_ready_i) begin
            mem[mem_addr_o] <= mem_wdata_o;
        end
    end

    // Protocol monitor and access/done counters
    always @(posedge clk) begin
        if ((mem_rd_o && mem_wr_o) ||
            (!rst && pend && ((mem_rd_o !== pend_rd) || (mem_wr_o !== pend_wr) ||
                              (mem_addr_o !== pend_addr) ||
                              (pend_wr && (mem_wdata_o !== pend_wdata)))))
            mon_err <= mon_err + 1;
        pend       <= !rst && (mem_rd_o || mem_wr_o) && !mem_ready_i;
        pend_rd    <= mem_rd_o;
        pend_wr    <= mem_wr_o;
        pend_addr  <= mem_addr_o;
        pend_wdata <= mem_wdata_o;
        if (mem_rd_o && mem_ready_i) rd_cnt <= rd_cnt + 1;
        if (mem_wr_o && mem_ready_i) wr_cnt <= wr_cnt + 1;
        if (done_o) done_cycles <= done_cycles + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_mem(input logic [31:0] vals);
        load_vals[0] = vals[31:24];
        load_vals[1] = vals[23:16];
        load_vals[2] = vals[15:8];
        load_vals[3] = vals[7:0];
        @(negedge clk) load_en = 1'b1;
        @(negedge clk) load_en = 1'b0;
    endtask

    function automatic logic [31:0] mem_word();
        return {mem[0], mem[1], mem[2], mem[3]};
    endfunction

    task automatic pulse_start(input logic d);
        @(negedge clk);
        start_i = 1'b1;
        desc_i  = d;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // Wait at falling edges for done_o, bounded; leaves us at the done cycle
    task automatic wait_done(input string tag);
        int n = 0;
        while (!done_o && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, {31'd0, !done_o}, 32'd0);
    endtask

    task automatic run_sort(input string tag, input logic d,
                            input logic [31:0] exp_mem, input logic [15:0] exp_swaps);
        int d0 = done_cycles;
        pulse_start(d);
        check({tag, "_busy_after_start"}, {31'd0, busy_o}, 32'd1);
        wait_done(tag);
        @(negedge clk);
        check({tag, "_done_single_cycle"}, {31'd0, done_o}, 32'd0);
        check({tag, "_busy_cleared"}, {31'd0, busy_o}, 32'd0);
        check({tag, "_mem"}, mem_word(), exp_mem);
        check({tag, "_swap_count"}, {16'd0, swap_count_o}, {16'd0, exp_swaps});
        check({tag, "_done_pulses"}, done_cycles - d0, 32'd1);
    endtask

    initial begin
        int r0, w0, m0, n;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy_o},   32'd0);
        check("rst_done",  {31'd0, done_o},   32'd0);
        check("rst_rd",    {31'd0, mem_rd_o}, 32'd0);
        check("rst_wr",    {31'd0, mem_wr_o}, 32'd0);
        check("rst_addr",  {30'd0, mem_addr_o}, 32'd0);
        check("rst_wdata", {24'd0, mem_wdata_o}, 32'd0);
        check("rst_swaps", {16'd0, swap_count_o}, 32'd0);
        rst = 1'b0;

        // Unsorted ascending, ready every cycle
        load_mem(32'h03010402);
        m0 = mon_err;
        run_sort("asc_3142", 1'b0, 32'h01020304, 16'd3);

        // Already sorted: one pass of three compares, no writes
        load_mem(32'h01020304);
        r0 = rd_cnt; w0 = wr_cnt;
        run_sort("asc_sorted", 1'b0, 32'h01020304, 16'd0);
        check("asc_sorted_reads",  rd_cnt - r0, 32'd6);
        check("asc_sorted_writes", wr_cnt - w0, 32'd0);

        // Descending on ascending data: full reversal
        load_mem(32'h01020304);
        run_sort("desc_1234", 1'b1, 32'h04030201, 16'd6);

        // Duplicates with random ready delay
        max_delay = 5;
        load_mem(32'h05050205);
        run_sort("asc_dup_delay", 1'b0, 32'h02050505, 16'd2);
        check("protocol_monitor", mon_err - m0, 32'd0);
        max_delay = 0;

        // Reset during WR_A of the first swap
        load_mem(32'h03010402);
        pulse_start(1'b0);
        n = 0;
        while (!mem_wr_o && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rst_mid_reached_wr", {31'd0, mem_wr_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_wr",    {31'd0, mem_wr_o}, 32'd0);
        check("rst_mid_rd",    {31'd0, mem_rd_o}, 32'd0);
        check("rst_mid_busy",  {31'd0, busy_o},   32'd0);
        check("rst_mid_swaps", {16'd0, swap_count_o}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_mem_untouched", mem_word(), 32'h03010402);
        run_sort("restart", 1'b0, 32'h01020304, 16'd3);

        // start and desc toggled while busy must be ignored
        load_mem(32'h04030201);
        m0 = done_cycles;
        pulse_start(1'b0);
        repeat (6) @(negedge clk);
        start_i = 1'b1;
        desc_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done("busy_start");
        @(negedge clk);
        desc_i = 1'b0;
        check("busy_start_mem",   mem_word(), 32'h01020304);
        check("busy_start_swaps", {16'd0, swap_count_o}, 32'd6);
        repeat (3) @(negedge clk);
        check("busy_start_one_done", done_cycles - m0, 32'd1);

        // mem_ready in IDLE is ignored; swap_count holds
        r0 = rd_cnt; w0 = wr_cnt;
        force_ready = 1'b1;
        repeat (4) @(negedge clk);
        force_ready = 1'b0;
        check("idle_ready_busy",   {31'd0, busy_o}, 32'd0);
        check("idle_ready_access", (rd_cnt - r0) + (wr_cnt - w0), 32'd0);
        check("idle_ready_swaps",  {16'd0, swap_count_o}, 32'd6);
        check("idle_ready_mem",    mem_word(), 32'h01020304);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
